// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control slice: controller state
// encoding and the canonical NOP instruction word (addi x0, x0, 0).
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_DRAIN    = 2'd2,
      ST_HALTED   = 2'd3
   } pipe_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int DRAIN_CNT_W = 4;

   // True when an ID source operand is read and names the given register.
   function automatic logic srcMatches(input logic used,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
      return used && (src == dst);
   endfunction

endpackage

// File: rtl/pipe_ctrl_perf_counter.sv
// Free-running 32-bit event counter with enable and synchronous clear.
// Wraps naturally from all-ones back to zero.
module perf_counter (
   input  logic        i_clk,
   input  logic        i_clear,
   input  logic        i_enable,
   output logic [31:0] o_count
);

   logic [31:0] r_count;

   // Clear has priority over counting so reset always lands on zero.
   always_ff @(posedge i_clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and pipeline-sequencing controller for a 5-stage in-order core.
// Handles load-use stalls, branch redirect flushes, data-memory wait
// stalls and the halt drain sequence, and keeps two performance counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [4:0]  i_id_rs1_addr,
   input  logic [4:0]  i_id_rs2_addr,
   input  logic        i_id_rs1_used,
   input  logic        i_id_rs2_used,
   input  logic        i_idex_valid,
   input  logic        i_idex_mem_read,
   input  logic [4:0]  i_idex_rd_addr,
   input  logic        i_ex_redirect,
   input  logic        i_exmem_valid,
   input  logic        i_exmem_mem_read,
   input  logic        i_exmem_mem_write,
   input  logic        i_exmem_retire_halt,
   input  logic        i_dmem_ready,
   output logic        o_stall_if,
   output logic        o_stall_id,
   output logic        o_stall_ex,
   output logic        o_stall_mem,
   output logic        o_flush_if_id,
   output logic        o_bubble_ex,
   output logic        o_bubble_wb,
   output logic        o_halted,
   output logic [31:0] o_cycle_count,
   output logic [31:0] o_stall_count
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

   pipe_state_t            r_state;
   logic [DRAIN_CNT_W-1:0] r_drain_cnt;

   pipe_state_t            w_next_state;
   logic [DRAIN_CNT_W-1:0] w_next_drain_cnt;
   logic                   w_mem_pending;
   logic                   w_load_use;
   logic                   w_cycle_en;
   logic                   w_stall_en;

   assign w_mem_pending = i_exmem_valid & (i_exmem_mem_read | i_exmem_mem_write)
                          & ~i_dmem_ready;

   assign w_load_use = i_idex_valid & i_idex_mem_read & (i_idex_rd_addr != 5'd0)
                       & (srcMatches(i_id_rs1_used, i_id_rs1_addr, i_idex_rd_addr)
                        | srcMatches(i_id_rs2_used, i_id_rs2_addr, i_idex_rd_addr));

   // Decode stall/flush controls and the next state; all outputs stay low in reset.
   always_comb begin
      o_stall_if       = 1'b0;
      o_stall_id       = 1'b0;
      o_stall_ex       = 1'b0;
      o_stall_mem      = 1'b0;
      o_flush_if_id    = 1'b0;
      o_bubble_ex      = 1'b0;
      o_bubble_wb      = 1'b0;
      o_halted         = 1'b0;
      w_next_state     = r_state;
      w_next_drain_cnt = r_drain_cnt;
      if (!i_rst) begin
         case (r_state)
            ST_RUN: begin
               if (w_mem_pending) begin
                  // Memory wait freezes everything; a redirect waits until it clears.
                  o_stall_if   = 1'b1;
                  o_stall_id   = 1'b1;
                  o_stall_ex   = 1'b1;
                  o_stall_mem  = 1'b1;
                  o_bubble_wb  = 1'b1;
                  w_next_state = ST_MEM_WAIT;
               end else begin
                  if (i_ex_redirect) begin
                     o_flush_if_id = 1'b1;
                     o_bubble_ex   = 1'b1;
                  end else if (w_load_use) begin
                     o_stall_if  = 1'b1;
                     o_stall_id  = 1'b1;
                     o_bubble_ex = 1'b1;
                  end
                  if (i_exmem_valid && i_exmem_retire_halt) begin
                     w_next_state     = ST_DRAIN;
                     w_next_drain_cnt = DRAIN_INIT;
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (w_mem_pending) begin
                  o_stall_if  = 1'b1;
                  o_stall_id  = 1'b1;
                  o_stall_ex  = 1'b1;
                  o_stall_mem = 1'b1;
                  o_bubble_wb = 1'b1;
               end else begin
                  // Ready cycle: let EX/MEM advance; deferred redirect acts next cycle.
                  w_next_state = ST_RUN;
               end
            end
            ST_DRAIN: begin
               o_stall_if       = 1'b1;
               o_flush_if_id    = 1'b1;
               w_next_drain_cnt = r_drain_cnt - 1'b1;
               if (r_drain_cnt <= DRAIN_CNT_W'(1)) begin
                  w_next_state = ST_HALTED;
               end
            end
            default: begin
               o_halted    = 1'b1;
               o_stall_if  = 1'b1;
               o_stall_id  = 1'b1;
               o_stall_ex  = 1'b1;
               o_stall_mem = 1'b1;
               o_bubble_ex = 1'b1;
               o_bubble_wb = 1'b1;
            end
         endcase
      end
   end

   // State and drain counter registers; reset overrides every other input.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_drain_cnt <= w_next_drain_cnt;
      end
   end

   assign w_cycle_en = ~i_rst & (r_state != ST_HALTED);
   assign w_stall_en = o_stall_if & (r_state != ST_HALTED);

   perf_counter u_cycle_counter (
      .i_clk    (i_clk),
      .i_clear  (i_rst),
      .i_enable (w_cycle_en),
      .o_count  (o_cycle_count)
   );

   perf_counter u_stall_counter (
      .i_clk    (i_clk),
      .i_clear  (i_rst),
      .i_enable (w_stall_en),
      .o_count  (o_stall_count)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes the response
// predicted by a behavioural model; a negedge monitor pops and compares.
module tb_pipe_ctrl;

   localparam int DRAIN = 3;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst;
   logic [4:0]  rs1Addr, rs2Addr, idexRd;
   logic        rs1Used, rs2Used, idexValid, idexMemRead, exRedirect;
   logic        exmemValid, exmemRead, exmemWrite, exmemHalt, dmemReady;
   logic        stallIf, stallId, stallEx, stallMem, flushIfId, bubbleEx, bubbleWb, halted;
   logic [31:0] cycleCount, stallCount;

   pipe_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .i_clk               (clock),
      .i_rst               (rst),
      .i_id_rs1_addr       (rs1Addr),
      .i_id_rs2_addr       (rs2Addr),
      .i_id_rs1_used       (rs1Used),
      .i_id_rs2_used       (rs2Used),
      .i_idex_valid        (idexValid),
      .i_idex_mem_read     (idexMemRead),
      .i_idex_rd_addr      (idexRd),
      .i_ex_redirect       (exRedirect),
      .i_exmem_valid       (exmemValid),
      .i_exmem_mem_read    (exmemRead),
      .i_exmem_mem_write   (exmemWrite),
      .i_exmem_retire_halt (exmemHalt),
      .i_dmem_ready        (dmemReady),
      .o_stall_if          (stallIf),
      .o_stall_id          (stallId),
      .o_stall_ex          (stallEx),
      .o_stall_mem         (stallMem),
      .o_flush_if_id       (flushIfId),
      .o_bubble_ex         (bubbleEx),
      .o_bubble_wb         (bubbleWb),
      .o_halted            (halted),
      .o_cycle_count       (cycleCount),
      .o_stall_count       (stallCount)
   );

   typedef struct {
      logic       rst;
      logic [4:0] rs1, rs2, rd;
      logic       rs1Used, rs2Used, idexValid, idexMemRead, redirect;
      logic       exmemValid, exmemRead, exmemWrite, exmemHalt, dmemReady;
   } stim_t;

   // ctrl bits: stall_if stall_id stall_ex stall_mem flush bubble_ex bubble_wb halted
   typedef struct {
      logic [7:0]  ctrl;
      logic [31:0] cycles;
      logic [31:0] stalls;
      bit          chkCnt;
      string       name;
   } expect_t;

   expect_t scoreQ[$];
   expect_t monItem;
   stim_t   nx;

   int checks = 0;
   int errors = 0;

   // Behavioural model: abstract pipeline condition rather than state codes.
   bit          mMemBusy = 1'b0;
   int          mDrainLeft = 0;
   bit          mHalted = 1'b0;
   bit          mKnown = 1'b0;
   logic [31:0] mCycles = '0;
   logic [31:0] mStalls = '0;

   bit          doPreload = 1'b0;
   logic [31:0] preCycles, preStalls;

   task automatic idle();
      nx.rst = 1'b0;
      nx.rs1 = 5'd0; nx.rs2 = 5'd0; nx.rd = 5'd0;
      nx.rs1Used = 1'b0; nx.rs2Used = 1'b0;
      nx.idexValid = 1'b0; nx.idexMemRead = 1'b0; nx.redirect = 1'b0;
      nx.exmemValid = 1'b0; nx.exmemRead = 1'b0; nx.exmemWrite = 1'b0;
      nx.exmemHalt = 1'b0; nx.dmemReady = 1'b1;
   endtask

   // Drive one cycle just after the edge, predict its response, advance the model.
   task automatic applyStimulus(input string name);
      logic [7:0] e;
      bit pend, lu;
      expect_t x;
      @(posedge clock);
      #1;
      rst = nx.rst; rs1Addr = nx.rs1; rs2Addr = nx.rs2; idexRd = nx.rd;
      rs1Used = nx.rs1Used; rs2Used = nx.rs2Used;
      idexValid = nx.idexValid; idexMemRead = nx.idexMemRead; exRedirect = nx.redirect;
      exmemValid = nx.exmemValid; exmemRead = nx.exmemRead; exmemWrite = nx.exmemWrite;
      exmemHalt = nx.exmemHalt; dmemReady = nx.dmemReady;
      if (doPreload) begin
         dut.u_cycle_counter.r_count = preCycles;
         dut.u_stall_counter.r_count = preStalls;
         mCycles = preCycles;
         mStalls = preStalls;
         doPreload = 1'b0;
      end
      pend = nx.exmemValid && (nx.exmemRead || nx.exmemWrite) && !nx.dmemReady;
      lu = nx.idexValid && nx.idexMemRead && (nx.rd != 5'd0) &&
           ((nx.rs1Used && nx.rs1 == nx.rd) || (nx.rs2Used && nx.rs2 == nx.rd));
      if (nx.rst)                        e = 8'b0000_0000;
      else if (mHalted)                  e = 8'b1111_0111;
      else if (mDrainLeft > 0)           e = 8'b1000_1000;
      else if (pend)                     e = 8'b1111_0010;
      else if (mMemBusy)                 e = 8'b0000_0000;
      else if (nx.redirect)              e = 8'b0000_1100;
      else if (lu)                       e = 8'b1100_0100;
      else                               e = 8'b0000_0000;
      x.ctrl = e; x.cycles = mCycles; x.stalls = mStalls; x.chkCnt = mKnown; x.name = name;
      scoreQ.push_back(x);
      if (nx.rst) begin
         mMemBusy = 1'b0; mDrainLeft = 0; mHalted = 1'b0;
         mCycles = '0; mStalls = '0; mKnown = 1'b1;
      end else begin
         if (!mHalted) begin
            mCycles = mCycles + 32'd1;
            if (e[7]) mStalls = mStalls + 32'd1;
         end
         if (mHalted) begin
         end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mHalted = 1'b1;
         end else begin
            if (!mMemBusy && !pend && nx.exmemValid && nx.exmemHalt) mDrainLeft = DRAIN;
            mMemBusy = pend;
         end
      end
   endtask

   // Monitor: compare the presented outputs against the oldest prediction.
   always @(negedge clock) begin
      if (scoreQ.size() > 0) begin
         monItem = scoreQ.pop_front();
         checkOutput(monItem);
      end
   end

   task automatic checkOutput(input expect_t x);
      logic [7:0] act;
      act = {stallIf, stallId, stallEx, stallMem, flushIfId, bubbleEx, bubbleWb, halted};
      checks++;
      if (act !== x.ctrl) begin
         errors++;
         $display("[TB] FAIL %s ctrl t=%0t got=%b want=%b", x.name, $time, act, x.ctrl);
      end
      if (x.chkCnt) begin
         checks++;
         if (cycleCount !== x.cycles) begin
            errors++;
            $display("[TB] FAIL %s cycle_count t=%0t got=%h want=%h", x.name, $time, cycleCount, x.cycles);
         end
         checks++;
         if (stallCount !== x.stalls) begin
            errors++;
            $display("[TB] FAIL %s stall_count t=%0t got=%h want=%h", x.name, $time, stallCount, x.stalls);
         end
      end
   endtask

   initial begin
      idle();
      rst = 1'b1; rs1Addr = '0; rs2Addr = '0; idexRd = '0; rs1Used = 0; rs2Used = 0;
      idexValid = 0; idexMemRead = 0; exRedirect = 0; exmemValid = 0; exmemRead = 0;
      exmemWrite = 0; exmemHalt = 0; dmemReady = 1;

      nx.rst = 1'b1; applyStimulus("reset"); applyStimulus("reset");
      idle(); applyStimulus("idle");

      // Load-use on x5 via rs1, then the bubble clears ID/EX.
      idle(); nx.idexValid = 1; nx.idexMemRead = 1; nx.rd = 5'd5; nx.rs1 = 5'd5; nx.rs1Used = 1;
      applyStimulus("loaduse_rs1");
      idle(); applyStimulus("loaduse_after");
      // Load into x0 never stalls.
      idle(); nx.idexValid = 1; nx.idexMemRead = 1; nx.rd = 5'd0; nx.rs1Used = 1; nx.rs2Used = 1;
      applyStimulus("loaduse_x0");
      // Redirect beats load-use.
      idle(); nx.idexValid = 1; nx.idexMemRead = 1; nx.rd = 5'd7; nx.rs2 = 5'd7; nx.rs2Used = 1;
      nx.redirect = 1; applyStimulus("redirect_vs_loaduse");

      // Store waits three cycles for memory.
      idle(); nx.rst = 1; applyStimulus("reset");
      idle(); nx.exmemValid = 1; nx.exmemWrite = 1; nx.dmemReady = 0;
      for (int i = 0; i < 3; i++) applyStimulus("store_wait");
      nx.dmemReady = 1; applyStimulus("store_ready");
      idle(); applyStimulus("store_done");

      // Redirect held during a load wait takes effect after ready.
      idle(); nx.exmemValid = 1; nx.exmemRead = 1; nx.dmemReady = 0; nx.redirect = 1;
      for (int i = 0; i < 2; i++) applyStimulus("deferred_redirect_wait");
      nx.dmemReady = 1; applyStimulus("deferred_redirect_ready");
      idle(); nx.redirect = 1; applyStimulus("deferred_redirect_flush");
      idle(); applyStimulus("idle");

      // Randomized traffic with occasional halts and resets.
      for (int i = 0; i < 400; i++) begin
         nx.rst         = ($urandom_range(0, 39) == 0);
         nx.rs1         = 5'($urandom_range(0, 3));
         nx.rs2         = 5'($urandom_range(0, 3));
         nx.rd          = 5'($urandom_range(0, 3));
         nx.rs1Used     = 1'($urandom_range(0, 1));
         nx.rs2Used     = 1'($urandom_range(0, 1));
         nx.idexValid   = 1'($urandom_range(0, 1));
         nx.idexMemRead = 1'($urandom_range(0, 1));
         nx.redirect    = ($urandom_range(0, 5) == 0);
         nx.exmemValid  = 1'($urandom_range(0, 1));
         nx.exmemRead   = ($urandom_range(0, 3) == 0);
         nx.exmemWrite  = ($urandom_range(0, 3) == 0);
         nx.exmemHalt   = ($urandom_range(0, 49) == 0);
         nx.dmemReady   = ($urandom_range(0, 3) != 0);
         applyStimulus("random");
      end

      // Halt drains for DRAIN cycles, then freezes the cycle counter.
      idle(); nx.rst = 1; applyStimulus("reset");
      idle(); applyStimulus("idle");
      nx.exmemValid = 1; nx.exmemHalt = 1; applyStimulus("halt_retire");
      idle();
      for (int i = 0; i < DRAIN; i++) applyStimulus("drain");
      for (int i = 0; i < 3; i++) applyStimulus("halted");

      // Preload near all-ones while halted; stays frozen, then reset clears.
      preCycles = 32'hFFFF_FFF0; preStalls = 32'hFFFF_FFF1; doPreload = 1;
      nx.redirect = 1; nx.exmemValid = 1; nx.exmemRead = 1; nx.dmemReady = 0;
      applyStimulus("halted_preload");
      applyStimulus("halted_frozen");
      idle(); nx.rst = 1; applyStimulus("reset_from_halted");
      idle(); applyStimulus("after_reset");

      // Wrap: both counters cross all-ones to zero.
      preCycles = 32'hFFFF_FFFE; preStalls = 32'hFFFF_FFFF; doPreload = 1;
      nx.idexValid = 1; nx.idexMemRead = 1; nx.rd = 5'd3; nx.rs1 = 5'd3; nx.rs1Used = 1;
      applyStimulus("wrap_stall");
      idle(); applyStimulus("wrap_1");
      applyStimulus("wrap_2");
      applyStimulus("idle");

      @(posedge clock);
      @(negedge clock);
      checks++;
      if (scoreQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_queue left=%0d want=0", scoreQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: post-halt drain length in cycles, legal range 1..15.
REQ-002 i_clk  input  1  clock, all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_id_rs1_addr / i_id_rs2_addr  input  5 each  ID-stage source registers.
REQ-005 i_id_rs1_used / i_id_rs2_used  input  1 each  ID instruction reads rs1 / rs2.
REQ-006 i_idex_valid, i_idex_mem_read  input  1 each  ID/EX slot valid; slot holds a load.
REQ-007 i_idex_rd_addr  input  5  ID/EX destination register.
REQ-008 i_ex_redirect  input  1  EX resolved a taken branch or jump.
REQ-009 i_exmem_valid, i_exmem_mem_read, i_exmem_mem_write, i_exmem_retire_halt  input  1 each  EX/MEM slot status.
REQ-010 i_dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 o_stall_if, o_stall_id, o_stall_ex, o_stall_mem  output  1 each  hold PC, IF/ID, ID/EX, EX/MEM registers.
REQ-012 o_flush_if_id, o_bubble_ex, o_bubble_wb  output  1 each  load NOP/invalid into IF/ID, ID/EX, MEM/WB.
REQ-013 o_halted  output  1  core halted.
REQ-014 o_cycle_count, o_stall_count  output  32 each  performance counters.

Function
REQ-015 States: RUN, MEM_WAIT, DRAIN, HALTED; encoded in 2 bits.
REQ-016 Load-use hazard in RUN: i_idex_valid & i_idex_mem_read & rd!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)).
REQ-017 Load-use in RUN asserts o_stall_if, o_stall_id, o_bubble_ex for that cycle only; no state change.
REQ-018 i_ex_redirect in RUN asserts o_flush_if_id and o_bubble_ex in the same cycle, with no stalls.
REQ-019 Redirect and load-use together: redirect wins, stalls deasserted.
REQ-020 Memory access pending = i_exmem_valid & (mem_read | mem_write) & !i_dmem_ready.
REQ-021 Pending in RUN or MEM_WAIT asserts all four stalls and o_bubble_wb; flush/bubble_ex suppressed, so a concurrent redirect is deferred.
REQ-022 RUN -> MEM_WAIT on pending; MEM_WAIT -> RUN on the edge where i_dmem_ready=1.
REQ-023 The ready cycle asserts no memory stall, so the EX/MEM contents advance on that edge.
REQ-024 A deferred redirect takes effect the cycle after the access completes.
REQ-025 i_exmem_valid & i_exmem_retire_halt, with no memory access pending, moves RUN -> DRAIN and loads a 4-bit drain counter with DRAIN_CYCLES.
REQ-026 DRAIN asserts o_stall_if and o_flush_if_id every cycle; the counter decrements per cycle.
REQ-027 DRAIN -> HALTED on the edge where the counter equals 1.
REQ-028 HALTED asserts o_halted plus all stalls, bubble_ex and bubble_wb; it is left only by reset.
REQ-029 o_cycle_count increments every non-reset cycle outside HALTED, wrapping 2^32-1 -> 0.
REQ-030 o_stall_count increments in any cycle with o_stall_if=1 outside HALTED, with the same wrap.
REQ-031 Stall/flush outputs are combinational from state and inputs; no combinational path from any output back to an input.

Reset
REQ-032 While i_rst=1, all stall/flush/bubble outputs and o_halted are 0; state and counters update on the edge.
REQ-033 After reset: state=RUN, drain counter=0, o_cycle_count=0, o_stall_count=0, o_halted=0.
REQ-034 Reset asserted in MEM_WAIT, DRAIN or HALTED returns to RUN on the next edge, overriding every other input.

Structure
REQ-035 The state encoding enum and the NOP constant 32'h00000013 live in shared package pipe_pkg.
REQ-036 The two performance counters are one reusable sub-module perf_counter (32-bit, enable, sync clear), instantiated twice.

Verification
REQ-037 Load-use: lw x5 in ID/EX, ID reads x5 via rs1 -> one cycle of stall_if=stall_id=bubble_ex=1, then 0; x0 as rd -> no stall.
REQ-038 Redirect plus load-use in the same cycle -> flush_if_id=1, bubble_ex=1, stall_if=0.
REQ-039 Store with i_dmem_ready low for 3 cycles -> stalls=1 and bubble_wb=1 for 3 cycles, RUN on the 4th; o_stall_count=3.
REQ-040 Redirect during MEM_WAIT held for 2 cycles -> flush asserted only in the cycle after ready.
REQ-041 Halt in EX/MEM with DRAIN_CYCLES=3 -> 3 DRAIN cycles, then o_halted=1; o_cycle_count frozen thereafter.
REQ-042 Reset in HALTED, plus counter preload near 2^32-1 in simulation -> RUN with counters 0; wrap to 0 checked separately.
